// File: rtl/countdown_pkg.sv
// Shared types and defaults for the seg7 countdown controller.
package countdown_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } cd_state_t;

   // Default clk cycles per decrement (1 s at 100 MHz).
   localparam int unsigned DEFAULT_PRESCALE = 100_000_000;

endpackage : countdown_pkg

// File: rtl/down_counter_core.sv
// Loadable WIDTH-bit down counter that saturates at zero instead of wrapping.
module down_counter_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] value
);

   // Count register: load has priority over decrement; decrement stops at 0.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (dec && (value != '0)) begin
         value <= value - WIDTH'(1);
      end
   end

endmodule : down_counter_core

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: FSM plus prescaler that drives the down counter core.
// A prescaler step is taken on every edge that leaves the FSM in RUN, except
// start; the edge that enters PAUSE freezes the prescaler and drops any tick.
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] init_data,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             paused,
   output logic             done,
   output logic             expired
);

   localparam int unsigned     PS_W    = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   cd_state_t        state, state_next;
   logic [PS_W-1:0]  presc, presc_next;
   logic             done_next;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             dec;
   logic             run_step;

   down_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .dec        (dec),
      .value      (count)
   );

   // State, prescaler and done-pulse registers.
   // NOTE: reset is synchronous active-high, matching the rest of this board codebase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         presc <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         presc <= presc_next;
         done  <= done_next;
      end
   end

   // Next-state logic in priority order abort > start > pause > tick.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_next = state;
      presc_next = presc;
      done_next  = 1'b0;
      load       = 1'b0;
      load_value = init_data;
      dec        = 1'b0;
      run_step   = 1'b0;

      if (abort) begin
         state_next = IDLE;
         presc_next = '0;
         load       = 1'b1;
         load_value = '0;
      end else if (start) begin
         presc_next = '0;
         load       = 1'b1;
         if (init_data != '0) begin
            state_next = RUN;
         end else begin
            state_next = DONE;
            done_next  = 1'b1;
         end
      end else begin
         if (state == RUN && pause) begin
            state_next = PAUSE;
         end
         run_step = (state == RUN && !pause) || (state == PAUSE && pause);
         if (run_step) begin
            state_next = RUN;
            if (presc == PS_LAST) begin
               presc_next = '0;
               dec        = 1'b1;
               if (count == WIDTH'(1)) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end
            end else begin
               presc_next = presc + PS_W'(1);
            end
         end
      end
   end

   // Status outputs decode the state register directly.
   assign running = (state == RUN);
   assign paused  = (state == PAUSE);
   assign expired = (state == DONE);

endmodule : countdown_ctrl

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with PRESCALE = 4.
module tb_countdown_ctrl;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] init_data;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             paused;
   logic             done;
   logic             expired;

   int total = 0;
   int bad   = 0;

   countdown_ctrl #(
      .WIDTH    (WIDTH),
      .PRESCALE (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pause     (pause),
      .abort     (abort),
      .init_data (init_data),
      .count     (count),
      .running   (running),
      .paused    (paused),
      .done      (done),
      .expired   (expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance past one rising edge and settle.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [WIDTH-1:0] v);
      init_data = v;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   int n_paused;
   int n_done;

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; init_data = '0;
      step(2);
      reset = 1'b0;

      // Reset then idle.
      step(10);
      check("idle_count",   count,   0);
      check("idle_running", running, 0);
      check("idle_paused",  paused,  0);
      check("idle_done",    done,    0);
      check("idle_expired", expired, 0);
      pause = 1'b1; step(); pause = 1'b0;
      check("idle_pause_ignored", paused, 0);

      // Plain countdown from 3.
      pulse_start(3);                               // after edge N
      check("c3_n_count",   count,   3);
      check("c3_n_running", running, 1);
      step(3);
      check("c3_n3_count",  count,   3);
      step();
      check("c3_n4_count",  count,   2);
      step(4);
      check("c3_n8_count",  count,   1);
      check("c3_n8_done",   done,    0);
      step(4);
      check("c3_n12_count",   count,   0);
      check("c3_n12_done",    done,    1);
      check("c3_n12_expired", expired, 1);
      check("c3_n12_running", running, 0);
      step();
      check("c3_n13_done",    done,    0);
      check("c3_n13_expired", expired, 1);
      step(3);
      check("c3_hold_expired", expired, 1);
      check("c3_hold_count",   count,   0);

      // Countdown from 5 with a pause between edges N+6 and N+16.
      pulse_start(5);
      n_paused = 0;
      n_done   = 0;
      for (int k = 1; k <= 30; k++) begin
         pause = (k == 6) || (k == 16);
         step();
         pause = 1'b0;
         if (paused) n_paused++;
         if (done)   n_done++;
         if (k == 6) begin
            check("p5_n6_paused", paused, 1);
            check("p5_n6_count",  count,  4);
         end
         if (k == 15) check("p5_n15_count", count, 4);
         if (k == 16) check("p5_n16_running", running, 1);
         if (k == 29) check("p5_n29_count", count, 1);
      end
      check("p5_n30_count",   count,    0);
      check("p5_n30_done",    done,     1);
      check("p5_paused_len",  n_paused, 10);
      check("p5_done_pulses", n_done,   1);

      // Start with zero: immediate expiry, never running.
      pulse_start(0);
      check("z_done",    done,    1);
      check("z_expired", expired, 1);
      check("z_count",   count,   0);
      check("z_running", running, 0);
      step();
      check("z_done_low", done,    0);
      check("z_running2", running, 0);

      // start and abort together while running at 7: abort wins.
      pulse_start(7);
      check("ab_count7", count, 7);
      init_data = 8; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("ab_count",   count,   0);
      check("ab_running", running, 0);
      check("ab_expired", expired, 0);
      check("ab_done",    done,    0);

      // Restart with 9 from PAUSE: prescaler begins again at 0.
      pulse_start(7);
      step();                                       // prescaler now 1
      pause = 1'b1; step(); pause = 1'b0;
      check("rs_paused", paused, 1);
      step(2);
      check("rs_frozen", count, 7);
      pulse_start(9);
      check("rs_count9",  count,   9);
      check("rs_running", running, 1);
      check("rs_paused0", paused,  0);
      step(3);
      check("rs_n3_count", count, 9);
      step();
      check("rs_n4_count", count, 8);

      // Reset in the middle of a run at count 2.
      pulse_start(3);
      step(4);
      check("rr_count2", count, 2);
      step(2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rr_count",   count,   0);
      check("rr_running", running, 0);
      check("rr_done",    done,    0);
      check("rr_expired", expired, 0);
      n_done = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (done) n_done++;
      end
      check("rr_no_done", n_done, 0);
      check("rr_idle_count", count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_countdown_ctrl

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the seg7 countdown datapath. It loads an initial value, divides `clk` down to a decrement tick, and supports start, pause/resume and abort. It stops at zero instead of wrapping and reports expiry. It sits between the board push-button pulse logic and the seg7 display driver, which consumes `count` directly.

## Interface
- `WIDTH`, 32, width of the loaded value and of `count`.
- `PRESCALE`, 100_000_000, `clk` cycles per decrement (≥2); benches use 4.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `start` in 1: one-cycle pulse; load `init_data` and run.
- `pause` in 1: one-cycle pulse; toggles RUN↔PAUSE; ignored in other states.
- `abort` in 1: one-cycle pulse; return to IDLE and clear count.
- `init_data` in WIDTH: value loaded on `start`; sampled only on the `start` cycle.
- `count` out WIDTH: current value, to the seg7 driver.
- `running` out 1: high in RUN.
- `paused` out 1: high in PAUSE.
- `done` out 1: one-cycle pulse on expiry.
- `expired` out 1: high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- Reset values of outputs:
  - `count` = 0, `done` = 0.
  - `running` = `paused` = `expired` = 0.
  - Internal prescaler = 0.
- Priority per cycle: `reset` > `abort` > `start` > `pause` > tick.
- `abort`, any state: go to IDLE, `count` ← 0, prescaler ← 0, no `done`.
- `start`, any state, including restart from RUN, PAUSE or DONE:
  - `count` ← `init_data`, prescaler ← 0.
  - Go to RUN if `init_data` ≠ 0.
  - Otherwise go to DONE and pulse `done`.
- RUN:
  - Prescaler increments each cycle.
  - At PRESCALE-1 the prescaler returns to 0 and a tick fires.
  - On tick with `count` > 1: `count` ← `count` − 1.
  - On tick with `count` == 1: `count` ← 0, go to DONE, `done` = 1 for one cycle.
- PAUSE:
  - Prescaler and `count` are frozen.
  - `pause` returns to RUN with the prescaler resuming from its held value.
- DONE: `count` holds 0 and `expired` = 1 until `start` or `abort`.
- Arithmetic: unsigned WIDTH-bit. `count` never wraps below 0. Prescaler width is $clog2(PRESCALE).
- `pause` arriving in the same cycle as a tick: pause wins, and the tick is not applied.

## Timing
- `start` sampled at edge N:
  - `count` = `init_data` and `running` = 1 after edge N.
  - First decrement is visible after edge N+PRESCALE.
- Value V ≥ 1 reaches 0 after edge N+V·PRESCALE, with no pauses.
- `done` is registered: it is high for exactly the cycle following the edge where `count` becomes 0, coincident with the first cycle of `expired`.
- `start` with `init_data` = 0 at edge N: `done` and `expired` are high after edge N.
- All outputs are registered; no combinational input→output paths.
- `reset` mid-operation: IDLE state and all reset values are restored after the next edge.

## Structure
- Package `countdown_pkg`:
  - State enum `cd_state_t` (IDLE, RUN, PAUSE, DONE).
  - Default `PRESCALE` constant.
- Sub-module `down_counter_core`:
  - Holds the WIDTH-bit register.
  - Inputs: `load`, `load_value`, `dec`.
  - Output: `value`, saturating at 0.
- `countdown_ctrl` owns the FSM and prescaler, and drives `load` and `dec`.

## Test plan
All scenarios use PRESCALE = 4.
- Reset, then idle 10 cycles → `count` = 0, all status outputs = 0.
- `start` with `init_data` = 3:
  - `count` reads 3, 2, 1, 0 at edges N, N+4, N+8, N+12.
  - `done` is high only in the cycle after N+12, then `expired` stays 1.
- `init_data` = 5, `pause` at N+6, `pause` again at N+16:
  - `count` holds 4 during PAUSE.
  - Reaches 0 at N+30.
  - `paused` is high for 10 cycles.
- `init_data` = 0 with `start` → `done` pulse and `expired` immediately; `count` = 0; `running` never asserts.
- In RUN with `count` = 7:
  - `start` and `abort` together → IDLE, `count` = 0.
  - A separate `start` with 9 during PAUSE → `count` = 9, RUN, prescaler restarted.
- `reset` asserted mid-RUN with `count` = 2 → next cycle IDLE, `count` = 0, no `done` pulse.
